// File: rtl/traffic_phase_controller.sv
// Purpose: N-phase traffic-light sequencer (green/extension/yellow/walk/all-red) with built-in tick-based interval timer.
// Latency: state, phase and countdown change on the clock edge where a tick expires them; lamps decode the registered state.
// Backpressure: none; tick, sensor, walk_req and programming writes are accepted on every cycle.
module traffic_phase_controller #(
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 8,
    parameter int T_GREEN    = 6,
    parameter int T_EXT      = 3,
    parameter int T_YELLOW   = 2,
    parameter int T_ALLRED   = 1,
    parameter int T_WALK     = 4,
    parameter int SKIP_EMPTY = 0,
    localparam int PW        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] sensor,
    input  logic [NUM_PHASES-1:0] walk_req,
    input  logic                  prog_en,
    input  logic [2:0]            prog_sel,
    input  logic [CNT_W-1:0]      prog_val,
    output logic [2:0]            state,
    output logic [PW-1:0]         phase,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] walk,
    output logic [NUM_PHASES-1:0] walk_pending,
    output logic [CNT_W-1:0]      remaining
);

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        GREEN  = 3'd1,
        EXT    = 3'd2,
        YELLOW = 3'd3,
        WALK   = 3'd4
    } stateT;

    stateT                 curState;
    stateT                 nextState;
    logic [PW-1:0]         curPhase;
    logic [PW-1:0]         nextPhase;
    logic [PW-1:0]         rrNext;
    logic [PW-1:0]         skipNext;
    logic [CNT_W-1:0]      remCnt;
    logic [CNT_W-1:0]      entryDur;
    logic [CNT_W-1:0]      durGreen;
    logic [CNT_W-1:0]      durExt;
    logic [CNT_W-1:0]      durYellow;
    logic [CNT_W-1:0]      durAllred;
    logic [CNT_W-1:0]      durWalk;
    logic [NUM_PHASES-1:0] pendReg;
    logic [NUM_PHASES-1:0] pendNext;
    logic [NUM_PHASES-1:0] pendClr;
    logic [NUM_PHASES-1:0] demand;
    logic                  expire;
    logic                  found;
    int                    idx;

    // A programmed duration of zero still has to occupy one tick.
    function automatic logic [CNT_W-1:0] loadVal(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    // Countdown of 1 (or a defensive 0) consumed by a tick ends the current state.
    assign expire = tick && (remCnt <= CNT_W'(1));
    assign demand = sensor | pendReg;

    // Candidate next phases: plain round-robin, and the first demanding phase after the current one.
    always_comb begin
        rrNext   = (curPhase == PW'(NUM_PHASES - 1)) ? '0 : curPhase + 1'b1;
        skipNext = rrNext;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i < NUM_PHASES; i++) begin
            idx = (int'(curPhase) + i) % NUM_PHASES;
            if (!found && demand[idx]) begin
                skipNext = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Next-state selection on expiry and the duration loaded for the state being entered.
    always_comb begin
        nextState = curState;
        nextPhase = curPhase;
        entryDur  = durAllred;
        if (expire) begin
            case (curState)
                ALLRED: begin
                    nextState = GREEN;
                    nextPhase = (SKIP_EMPTY != 0) ? skipNext : rrNext;
                end
                GREEN:   nextState = sensor[curPhase] ? EXT : YELLOW;
                EXT:     nextState = YELLOW;
                YELLOW:  nextState = pendReg[curPhase] ? WALK : ALLRED;
                WALK:    nextState = ALLRED;
                default: nextState = ALLRED;
            endcase
        end
        case (nextState)
            GREEN:   entryDur = durGreen;
            EXT:     entryDur = durExt;
            YELLOW:  entryDur = durYellow;
            WALK:    entryDur = durWalk;
            default: entryDur = durAllred;
        endcase
    end

    // Walk latch: cleared when its phase enters WALK, but a still-pressed button re-arms it.
    always_comb begin
        pendClr = '0;
        if (expire && (curState == YELLOW) && (nextState == WALK)) begin
            pendClr = NUM_PHASES'(1) << curPhase;
        end
        pendNext = (pendReg & ~pendClr) | walk_req;
    end

    // Sequencer state, owning phase, countdown and walk latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState <= ALLRED;
            curPhase <= PW'(NUM_PHASES - 1);
            remCnt   <= loadVal(CNT_W'(T_ALLRED));
            pendReg  <= '0;
        end else begin
            pendReg <= pendNext;
            if (expire) begin
                curState <= nextState;
                curPhase <= nextPhase;
                remCnt   <= loadVal(entryDur);
            end else if (tick) begin
                remCnt <= remCnt - 1'b1;
            end
        end
    end

    // Duration registers; a write only shows up at the next state entry after it lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            durGreen  <= CNT_W'(T_GREEN);
            durExt    <= CNT_W'(T_EXT);
            durYellow <= CNT_W'(T_YELLOW);
            durAllred <= CNT_W'(T_ALLRED);
            durWalk   <= CNT_W'(T_WALK);
        end else if (prog_en) begin
            case (prog_sel)
                3'd0:    durGreen  <= prog_val;
                3'd1:    durExt    <= prog_val;
                3'd2:    durYellow <= prog_val;
                3'd3:    durAllred <= prog_val;
                3'd4:    durWalk   <= prog_val;
                default: ;
            endcase
        end
    end

    // Lamp decode of the registered state and owning phase.
    always_comb begin
        green  = '0;
        yellow = '0;
        walk   = '0;
        case (curState)
            GREEN, EXT: green[curPhase]  = 1'b1;
            YELLOW:     yellow[curPhase] = 1'b1;
            WALK:       walk[curPhase]   = 1'b1;
            default:    ;
        endcase
        red = ~(green | yellow);
    end

    assign state        = curState;
    assign phase        = curPhase;
    assign remaining    = remCnt;
    assign walk_pending = pendReg;

endmodule
